gate_truth_checker: RTL and testbench
=====================================

# gate_truth_checker

Synthesizable self-checking driver for two-input logic gates: drives the gate's A and B inputs through all four input combinations, waits a programmable settle time, samples the gate's Y output and compares it against a parameterised truth table. It sits alongside a gate instance such as a NAND in on-chip self-test builds and reports pass/fail, an error count and a per-vector failure mask. It replaces a simulation-only stimulus and display sequence with clocked hardware.

## Interface

Parameters:
- TRUTH, 4'b0111, expected Y per input vector; bit index = {A,B}; default is NAND.
- SETTLE, 4, cycles between driving a vector and sampling Y; must be ≥ 1.
- ERR_W, 3, width of the error counter; must be ≥ 3.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  begin a test run; honoured only in IDLE.
- Y  in  1  output of the gate under test; combinational from A and B.
- A  out  1  gate input A; registered.
- B  out  1  gate input B; registered.
- BUSY  out  1  high from START acceptance through the last SAMPLE cycle.
- DONE  out  1  single-cycle pulse when the run completes.
- PASS  out  1  high after a run with zero mismatches; held until the next START.
- ERR_CNT  out  ERR_W  mismatch count, saturating; held until the next START.
- FAIL_MASK  out  4  bit v set if vector v mismatched; held until the next START.

## Operation

- States: IDLE, SETTLE, SAMPLE, FIN.
- IDLE with START=1:
  - vec←0, {A,B}←2'b00, cnt←0.
  - ERR_CNT←0, FAIL_MASK←0, PASS←0.
  - Go to SETTLE.
- SETTLE: cnt increments each cycle. When cnt==SETTLE-1, go to SAMPLE.
- SAMPLE:
  - Compare Y against TRUTH[vec].
  - On mismatch: FAIL_MASK[vec]←1 and ERR_CNT increments, saturating at all-ones.
  - If vec==3, go to FIN. Otherwise vec←vec+1, {A,B}←vec+1, cnt←0, and go to SETTLE.
- FIN:
  - DONE=1 for this cycle only.
  - PASS←1 if no vector mismatched, counting the mismatch recorded in the final SAMPLE.
  - Go to IDLE.
- Vector order is fixed: 00, 01, 10, 11.
- START outside IDLE is ignored, including in FIN. No queueing.
- Y is sampled only in SAMPLE. Y glitches in other states have no effect.
- A and B change only on entry to a vector. They hold 2'b11 after the run until the next START.

## Timing

- Reset values: A=0, B=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0, FAIL_MASK=0. State is IDLE.
- Each vector occupies SETTLE+1 cycles: SETTLE cycles in SETTLE plus 1 cycle in SAMPLE.
- Take START sampled at edge 0. Then:
  - A/B=00 is valid after edge 0.
  - Vector v is sampled in cycle (v+1)(SETTLE+1)−1.
  - DONE is high in cycle 4(SETTLE+1). With SETTLE=4 this is cycle 20.
- PASS, ERR_CNT and FAIL_MASK are final and valid in the same cycle DONE is high.
- BUSY falls in the FIN cycle.
- Back-to-back runs: START is accepted one cycle after DONE, once the block is in IDLE.
- Reset asserted mid-run takes effect immediately, without waiting for a clock edge. All outputs return to reset values and no DONE is produced.

## Structure

- Shared package gate_chk_pkg holds:
  - the state enum;
  - truth constants TT_NAND=4'b0111, TT_AND=4'b1000, TT_OR=4'b1110, TT_NOR=4'b0001, TT_XOR=4'b0110.
- Optional sub-module gate_chk_settle_timer: a loadable down-counter with a single expiry flag.
- Everything else stays in one module.

## Test plan

- Correct NAND, SETTLE=4, START at cycle 0:
  - A/B step 00, 01, 10, 11 at cycles 0, 5, 10, 15.
  - DONE at cycle 20; PASS=1, ERR_CNT=0, FAIL_MASK=4'b0000.
- Y stuck at 1, TRUTH=NAND: PASS=0, ERR_CNT=1, FAIL_MASK=4'b1000.
- DUT is an AND gate, TRUTH=NAND: ERR_CNT=4, FAIL_MASK=4'b1111, PASS=0.
- TRUTH=TT_AND with an AND DUT: PASS=1. Then pulse START at cycle 7 while BUSY: the run is unaffected and DONE still occurs at cycle 20.
- RST_N low at cycle 12 mid-run:
  - All outputs return to reset values immediately.
  - No DONE pulse.
  - A fresh START after release completes normally.
- Second START one cycle after DONE: ERR_CNT, FAIL_MASK and PASS clear on acceptance and the run repeats with identical timing.

Source files
------------

// File: rtl/gate_chk_pkg.sv
// Shared definitions for the two-input gate truth-table checker.
package gate_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_FIN
  } state_e;

  // Expected Y per input vector, bit index = {A,B}.
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;

endpackage

// File: rtl/gate_truth_checker.sv
// Walks a two-input gate through all four input vectors, samples Y after a
// settle delay and scores it against TRUTH.
module gate_truth_checker
  import gate_chk_pkg::*;
#(
  parameter logic [3:0] TRUTH  = TT_NAND,
  parameter int         SETTLE = 4,
  parameter int         ERR_W  = 3
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             Y,
  output logic             A,
  output logic             B,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic [3:0]       FAIL_MASK
);

  localparam int CNT_W = $clog2(SETTLE + 1);

  state_e           state_q, state_d;
  logic [1:0]       vec_q, vec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [3:0]       mask_q, mask_d;
  logic             pass_q, pass_d;

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    mask_d  = mask_q;
    pass_d  = pass_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          vec_d   = 2'b00;
          cnt_d   = '0;
          err_d   = '0;
          mask_d  = 4'b0000;
          pass_d  = 1'b0;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(SETTLE - 1)) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        if (Y != TRUTH[vec_q]) begin
          mask_d[vec_q] = 1'b1;
          if (err_q != {ERR_W{1'b1}}) begin
            err_d = err_q + 1'b1;
          end
        end
        if (vec_q == 2'd3) begin
          // PASS is resolved on entry to FIN so it is valid alongside DONE.
          pass_d  = (mask_d == 4'b0000);
          state_d = ST_FIN;
        end else begin
          vec_d   = vec_q + 2'd1;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      vec_q   <= 2'b00;
      cnt_q   <= '0;
      err_q   <= '0;
      mask_q  <= 4'b0000;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
      pass_q  <= pass_d;
    end
  end

  // The vector register doubles as the registered gate drive.
  assign A         = vec_q[1];
  assign B         = vec_q[0];
  assign BUSY      = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign DONE      = (state_q == ST_FIN);
  assign PASS      = pass_q;
  assign ERR_CNT   = err_q;
  assign FAIL_MASK = mask_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Scoreboard bench: two checker instances (NAND/SETTLE=4, AND/SETTLE=2)
// driving modelled gates with glitchy Y outside their sample cycles.
module tb_gate_truth_checker;
  import gate_chk_pkg::*;

  localparam int S0 = 4;
  localparam int S1 = 2;

  typedef struct {
    int         done_cyc;
    logic       pass;
    logic [2:0] err;
    logic [3:0] mask;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] start;
  logic [1:0] y;
  logic [1:0] a;
  logic [1:0] b;
  logic [1:0] busy;
  logic [1:0] done;
  logic [1:0] pass;
  logic [2:0] err [2];
  logic [3:0] mask [2];
  logic [3:0] lut_g [2];
  logic [1:0] glitch;

  int   cyc = -1;
  int   run_start [2];
  bit   run_valid [2];
  int   compared = 0;
  int   mismatched = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gate_truth_checker #(.TRUTH(TT_NAND), .SETTLE(S0), .ERR_W(3)) u_dut0 (
    .CLK(clk), .RST_N(rst_n), .START(start[0]), .Y(y[0]),
    .A(a[0]), .B(b[0]), .BUSY(busy[0]), .DONE(done[0]), .PASS(pass[0]),
    .ERR_CNT(err[0]), .FAIL_MASK(mask[0])
  );

  gate_truth_checker #(.TRUTH(TT_AND), .SETTLE(S1), .ERR_W(3)) u_dut1 (
    .CLK(clk), .RST_N(rst_n), .START(start[1]), .Y(y[1]),
    .A(a[1]), .B(b[1]), .BUSY(busy[1]), .DONE(done[1]), .PASS(pass[1]),
    .ERR_CNT(err[1]), .FAIL_MASK(mask[1])
  );

  // Gate under test: a 4-entry lookup on {A,B}, plus random glitches.
  assign y[0] = lut_g[0][{a[0], b[0]}] ^ glitch[0];
  assign y[1] = lut_g[1][{a[1], b[1]}] ^ glitch[1];

  function automatic int settle_of(input int id);
    return (id == 0) ? S0 : S1;
  endfunction

  function automatic logic [3:0] truth_of(input int id);
    return (id == 0) ? TT_NAND : TT_AND;
  endfunction

  function automatic void chk(input string name, input int id, input int act, input int expv);
    compared++;
    if (act != expv) begin
      mismatched++;
      $display("FAIL %s dut%0d @cyc %0d: got %0d, expected %0d", name, id, cyc, act, expv);
    end
  endfunction

  // Reference model: mismatch set is where the gate's table differs from TRUTH.
  function automatic exp_t model(input int id, input logic [3:0] lut, input int se);
    exp_t       e;
    logic [3:0] tt;
    int         n;
    tt     = truth_of(id);
    n      = 0;
    e.mask = 4'b0000;
    for (int v = 0; v < 4; v++) begin
      if (lut[v] != tt[v]) begin
        e.mask[v] = 1'b1;
        n++;
      end
    end
    e.err      = (n > 7) ? 3'd7 : 3'(n);
    e.pass     = (n == 0);
    e.done_cyc = se + 4 * (settle_of(id) + 1);
    return e;
  endfunction

  function automatic void push_exp(input int id, input exp_t e);
    if (id == 0) q0.push_back(e);
    else         q1.push_back(e);
  endfunction

  function automatic bit pop_exp(input int id, output exp_t e);
    e = '{default: 0};
    if (id == 0) begin
      if (q0.size() == 0) return 1'b0;
      e = q0.pop_front();
    end else begin
      if (q1.size() == 0) return 1'b0;
      e = q1.pop_front();
    end
    return 1'b1;
  endfunction

  // Glitch Y everywhere except the cycle each vector is sampled in.
  always @(negedge clk) begin
    for (int id = 0; id < 2; id++) begin
      int t;
      bit samp;
      t    = cyc - run_start[id];
      samp = run_valid[id] && (t >= 0) && (((t + 1) % (settle_of(id) + 1)) == 0);
      glitch[id] <= samp ? 1'b0 : 1'($urandom_range(0, 1));
    end
  end

  // Monitor: vector sequencing during a run, and scoreboard pop on DONE.
  always @(negedge clk) begin
    for (int id = 0; id < 2; id++) begin
      int   t;
      int   per;
      exp_t e;
      per = settle_of(id) + 1;
      t   = cyc - run_start[id];
      if (run_valid[id] && t >= 0 && t < 4 * per) begin
        chk("ab_vector", id, int'({a[id], b[id]}), t / per);
        chk("busy_run", id, int'(busy[id]), 1);
      end
      if (done[id]) begin
        if (!pop_exp(id, e)) begin
          chk("unexpected_done", id, 1, 0);
        end else begin
          chk("done_cycle", id, cyc, e.done_cyc);
          chk("pass", id, int'(pass[id]), int'(e.pass));
          chk("err_cnt", id, int'(err[id]), int'(e.err));
          chk("fail_mask", id, int'(mask[id]), int'(e.mask));
          chk("busy_fin", id, int'(busy[id]), 0);
          chk("ab_hold", id, int'({a[id], b[id]}), 3);
        end
      end
    end
  end

  task automatic check_reset_vals(input int id, input string tag);
    chk({tag, "_a"}, id, int'(a[id]), 0);
    chk({tag, "_b"}, id, int'(b[id]), 0);
    chk({tag, "_busy"}, id, int'(busy[id]), 0);
    chk({tag, "_done"}, id, int'(done[id]), 0);
    chk({tag, "_pass"}, id, int'(pass[id]), 0);
    chk({tag, "_err"}, id, int'(err[id]), 0);
    chk({tag, "_mask"}, id, int'(mask[id]), 0);
  endtask

  // Called at a negedge. early=1 raises START during the FIN cycle of the
  // previous run so that it must be ignored there and accepted a cycle later.
  task automatic do_run(input int id, input logic [3:0] lut, input bit early,
                        input int poke, input int abort);
    int   se;
    exp_t e;
    lut_g[id]     = lut;
    se            = cyc + (early ? 2 : 1);
    run_start[id] = se;
    run_valid[id] = 1'b1;
    e             = model(id, lut, se);
    if (abort == 0) push_exp(id, e);
    start[id] = 1'b1;
    if (early) @(negedge clk);
    @(negedge clk);
    start[id] = 1'b0;
    chk("clr_pass", id, int'(pass[id]), 0);
    chk("clr_err", id, int'(err[id]), 0);
    chk("clr_mask", id, int'(mask[id]), 0);
    if (poke > 0) begin
      while (cyc < se + poke) @(negedge clk);
      start[id] = 1'b1;
      @(negedge clk);
      start[id] = 1'b0;
    end
    if (abort > 0) begin
      while (cyc < se + abort) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_vals(id, "abort");
      run_valid[id] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      $display("run dut%0d lut=%b aborted by reset at cyc %0d", id, lut, se + abort);
    end else begin
      while (cyc < e.done_cyc) @(negedge clk);
      $display("run dut%0d lut=%b start@%0d done@%0d pass=%0b err=%0d mask=%b",
               id, lut, se, e.done_cyc, e.pass, e.err, e.mask);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   prev_id;
    int   id;
    int   poke;
    bit   early;
    rst_n        = 1'b0;
    start        = 2'b00;
    lut_g[0]     = TT_NAND;
    lut_g[1]     = TT_AND;
    run_start[0] = 0;
    run_start[1] = 0;
    run_valid[0] = 1'b0;
    run_valid[1] = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals(0, "rst");
    check_reset_vals(1, "rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals(0, "idle");

    do_run(0, TT_NAND, 1'b0, 0, 0);   // correct NAND
    @(negedge clk);
    do_run(0, 4'b1111, 1'b0, 0, 0);   // Y stuck at 1
    @(negedge clk);
    do_run(0, TT_AND, 1'b0, 0, 0);    // AND gate against NAND table
    @(negedge clk);
    do_run(1, TT_AND, 1'b0, 7, 0);    // START poked mid-run
    @(negedge clk);
    do_run(0, TT_AND, 1'b0, 0, 12);   // reset mid-run
    @(negedge clk);
    do_run(0, TT_NAND, 1'b0, 0, 0);   // fresh run after reset
    do_run(0, TT_XOR, 1'b1, 0, 0);    // back-to-back
    do_run(0, TT_XOR, 1'b1, 0, 0);
    prev_id = 0;

    for (int r = 0; r < 24; r++) begin
      id    = $urandom_range(0, 1);
      early = (id == prev_id) && ($urandom_range(0, 1) == 1);
      poke  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 4 * (settle_of(id) + 1) - 1) : 0;
      if (!early) @(negedge clk);
      do_run(id, 4'($urandom_range(0, 15)), early, poke, 0);
      prev_id = id;
    end

    repeat (5) @(negedge clk);
    chk("leftover_exp0", 0, q0.size(), 0);
    chk("leftover_exp1", 1, q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
